// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a one-entry holding register and error flags
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic       rd_uart,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state, state_n;
    logic [4:0] s, s_n;
    logic [2:0] n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic perr, perr_n;
    logic sync1, rx_s, armed;
    logic [1:0] fill;
    logic exp_par;
    assign exp_par = (PARITY == 1) ? ~^b : ^b;
    // fill gates arming until rx_s carries a real line sample, not the reset value of the synchroniser
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & rx_s);
        end
    end
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
            perr  <= perr_n;
        end
    end
    always_comb begin
        state_n      = state;
        s_n          = s;
        n_n          = n;
        b_n          = b;
        perr_n       = perr;
        rx_done_tick = 1'b0;
        case (state)
            IDLE: if (armed && !rx_s) begin
                state_n = START;
                s_n     = '0;
            end
            START: if (s_tick) begin
                if (s == 5'd7) begin
                    state_n = rx_s ? IDLE : DATA;
                    s_n     = '0;
                    n_n     = '0;
                end else s_n = s + 5'd1;
            end
            DATA: if (s_tick) begin
                if (s == 5'd15) begin
                    s_n = '0;
                    b_n = {rx_s, b[DBIT-1:1]};
                    if (n == 3'(DBIT - 1)) state_n = (PARITY != 0) ? PAR : STOP;
                    else n_n = n + 3'd1;
                end else s_n = s + 5'd1;
            end
            PAR: if (s_tick) begin
                if (s == 5'd15) begin
                    s_n     = '0;
                    perr_n  = rx_s != exp_par;
                    state_n = STOP;
                end else s_n = s + 5'd1;
            end
            STOP: if (s_tick) begin
                if (s == 5'(SB_TICK - 1)) begin
                    rx_done_tick = 1'b1;
                    state_n      = IDLE;
                end else s_n = s + 5'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            dout        <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (rx_done_tick) begin
            dout        <= 8'(b);
            parity_err  <= perr;
            frame_err   <= ~rx_s;
            rx_valid    <= 1'b1;
            overrun_err <= rx_valid & ~rd_uart;
        end else if (rd_uart && rx_valid) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the TP2 UART link; the receive side of the 16x-oversampled serial format driven by the transmitter.
- Synchronises the asynchronous rx line and detects/validates start bits at mid-bit.
- Shifts DBIT data bits in LSB first, checks optional parity and the stop bit.
- Presents each byte in a one-entry holding register with a read handshake and error flags, for the interface/ALU control logic.

Parameters:
DBIT, 8, number of data bits per frame (5..8)
SB_TICK, 16, s_tick count for stop bit (16/24/32 = 1/1.5/2 stop bits)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
i_clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to i_clk
s_tick  in  1  one-clock enable pulse at 16x baud rate from baud generator
rd_uart  in  1  consumer pop strobe; clears rx_valid
dout  out  8  received data, right-aligned, bits above DBIT-1 zero
rx_valid  out  1  holding register contains unread byte
rx_done_tick  out  1  one-clock pulse when a frame completes
parity_err  out  1  parity mismatch for byte in dout (0 when PARITY=0)
frame_err  out  1  stop bit sampled low for byte in dout
overrun_err  out  1  sticky: unread byte was overwritten

Behaviour:
- Reset (reset=0, async): FSM idle, s/n counters 0, shift reg 0, both sync flops 1, armed=0.
  - All outputs 0: dout, rx_valid, rx_done_tick, parity_err, frame_err, overrun_err.
- Synchroniser: 2 flops, rx_s = rx delayed 2 clocks. The FSM uses only rx_s.
- Arm rule: idle ignores rx_s until rx_s has been 1 for at least one clock (armed=1).
  - Prevents false starts when reset is released mid-frame or with the line low.
  - armed stays 1 until reset.
- FSM states and transitions:
  - idle: armed and rx_s==0 -> start, s=0.
  - start: on s_tick: if s==7, then rx_s==0 -> data with s=0, n=0; else -> idle (glitch rejected, no pulse, no flags). Otherwise s++.
  - data: on s_tick: if s==15, then s=0 and shift rx_s in at MSB of a DBIT-wide shift reg. If n==DBIT-1, go to parity (PARITY!=0) or stop; else n++. Otherwise s++.
  - parity: on s_tick: if s==15, then s=0, perr_int = (rx_s != expected), -> stop. Expected bit: odd = ~^data, even = ^data. Otherwise s++.
  - stop: on s_tick: if s==SB_TICK-1, then ferr_int = ~rx_s, rx_done_tick=1 (combinational, one clock), -> idle. Otherwise s++.
- s_tick low: counters and state hold, except the idle->start transition, which needs no tick.
- Holding register, updated in the clock following the rx_done_tick cycle:
  - dout, parity_err, frame_err are loaded, and rx_valid=1.
  - A frame with a frame error is still delivered, with frame_err=1.
- Overrun: if rx_valid==1 at done and rd_uart is not asserted that same cycle, then overrun_err=1 and the new byte overwrites dout.
- rd_uart with rx_valid==1: rx_valid=0, overrun_err=0. dout, parity_err and frame_err hold their values.
- rd_uart with rx_valid==0: ignored.
- rd_uart and done in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- Reset mid-frame: frame discarded, no rx_done_tick, holding register cleared.
- Latency: rx edge to start detect is 2 clocks. rx_done_tick fires at the end of the stop sampling tick. rx_valid rises 1 clock after rx_done_tick.

Test Plan:
1. s_tick every 4 clks, PARITY=0; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one rx_done_tick; dout=0xA5, rx_valid=1, all errors 0.
2. rx low for 5 s_ticks then high -> back to idle, no rx_done_tick, no flags; following frame 0x3C -> dout=0x3C.
3. Send 0x55 with stop bit driven 0 -> dout=0x55, frame_err=1, rx_valid=1; next good frame 0x0F -> frame_err=0.
4. PARITY=2, send 0x07 with parity bit 0 -> parity_err=1; resend 0x07 with parity bit 1 -> parity_err=0. PARITY=1, send 0x07 with parity bit 0 -> parity_err=0.
5. Send 0x11 then 0x22 with no rd_uart -> dout=0x22, overrun_err=1. Pulse rd_uart -> rx_valid=0, overrun_err=0. Then time rd_uart coincident with rx_done_tick of 0x33 after an unread byte -> overrun_err stays 0, rx_valid=1, dout=0x33.
6. Assert reset mid data bit 3 of 0xFF; release with rx held low -> no start detected. Raise rx, then send 0x81 -> dout=0x81, single rx_done_tick. Also check DBIT=7 frame 0x7F -> dout=0x7F, dout[7]=0.
